// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares the single mem_cntrl port between NUM_REQ requesters. Arbitration is
// round-robin; a grant is held for one full transaction (until mem_tx_done)
// and is followed by one dead cycle (RELEASE) so the finished requester can
// drop its op before the next arbitration. A watchdog forces release when
// mem_cntrl never signals completion.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   req_op            per-requester op, slice i = [2i+1:2i] (01 RD, 11 WR)
//   req_addr          per-requester address, slice i = [ADDR_W*i +: ADDR_W]
//   req_wdata         per-requester write data, slice i = [DATA_W*i +: DATA_W]
//   req_rdata         read data broadcast to all requesters
//   req_rd_valid      rd_valid routed to the granted requester only
//   req_tx_done       tx_done routed to the granted requester only
//   grant             one-hot owner, zero outside BUSY
//   mem_op/addr/wdata request side towards mem_cntrl (zero outside BUSY)
//   mem_rdata         read data from mem_cntrl
//   mem_rd_valid      read beat valid from mem_cntrl
//   mem_tx_done       transaction complete from mem_cntrl
//   busy              high while a transaction is granted
//   timeout_err       one-cycle pulse in the BUSY cycle that is force-released
// -----------------------------------------------------------------------------
module mem_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int ADDR_W  = 64,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 1024
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [2*NUM_REQ-1:0]        req_op,
   input  logic [ADDR_W*NUM_REQ-1:0]   req_addr,
   input  logic [DATA_W*NUM_REQ-1:0]   req_wdata,
   output logic [DATA_W-1:0]           req_rdata,
   output logic [NUM_REQ-1:0]          req_rd_valid,
   output logic [NUM_REQ-1:0]          req_tx_done,
   output logic [NUM_REQ-1:0]          grant,
   output logic [1:0]                  mem_op,
   output logic [ADDR_W-1:0]           mem_addr,
   output logic [DATA_W-1:0]           mem_wdata,
   input  logic [DATA_W-1:0]           mem_rdata,
   input  logic                        mem_rd_valid,
   input  logic                        mem_tx_done,
   output logic                        busy,
   output logic                        timeout_err
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int WD_W  = $clog2(TIMEOUT);

   localparam logic [IDX_W-1:0] LAST_RST  = IDX_W'(NUM_REQ - 1);
   localparam logic [WD_W-1:0]  WD_MAX    = WD_W'(TIMEOUT - 1);
   localparam logic [IDX_W:0]   NUM_REQ_E = (IDX_W + 1)'(NUM_REQ);

   typedef enum logic [1:0] {
      S_IDLE    = 2'b00,
      S_BUSY    = 2'b01,
      S_RELEASE = 2'b10
   } state_t;

   state_t             state_q, state_d;
   logic [NUM_REQ-1:0] grant_q, grant_d;
   logic [IDX_W-1:0]   gidx_q, gidx_d;
   logic [IDX_W-1:0]   last_q, last_d;
   logic [WD_W-1:0]    wdog_q, wdog_d;

   logic [NUM_REQ-1:0] active_s;
   logic               pick_found_s;
   logic [IDX_W-1:0]   pick_idx_s;
   logic [IDX_W:0]     cand_s;
   logic               wd_expire_s;

   // Active requesters: only READ (01) and WRITE (11); reserved 10 never wins.
   always_comb begin
      active_s = {NUM_REQ{1'b0}};
      for (int i = 0; i < NUM_REQ; i++) begin
         active_s[i] = req_op[2*i] && (req_op[2*i+1 -: 2] != 2'b10);
      end
   end

   // Round-robin pick. Offsets are scanned from farthest to nearest so the
   // nearest active requester after last_q overwrites the others and wins.
   always_comb begin
      pick_found_s = 1'b0;
      pick_idx_s   = {IDX_W{1'b0}};
      cand_s       = {(IDX_W+1){1'b0}};
      for (int k = NUM_REQ; k >= 1; k--) begin
         cand_s = {1'b0, last_q} + (IDX_W + 1)'(k);
         if (cand_s >= NUM_REQ_E) begin
            cand_s = cand_s - NUM_REQ_E;
         end else begin
            cand_s = cand_s;
         end
         if (active_s[cand_s[IDX_W-1:0]]) begin
            pick_found_s = 1'b1;
            pick_idx_s   = cand_s[IDX_W-1:0];
         end else begin
            pick_found_s = pick_found_s;
         end
      end
   end

   // Watchdog expiry; a coincident mem_tx_done takes precedence.
   always_comb begin
      if (state_q == S_BUSY) begin
         wd_expire_s = (wdog_q == WD_MAX) && !mem_tx_done;
      end else begin
         wd_expire_s = 1'b0;
      end
   end

   // Next-state logic for the arbitration FSM, grant and watchdog.
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      gidx_d  = gidx_q;
      last_d  = last_q;
      wdog_d  = wdog_q;
      case (state_q)
         S_IDLE: begin
            if (pick_found_s) begin
               state_d = S_BUSY;
               grant_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx_s;
               gidx_d  = pick_idx_s;
               wdog_d  = {WD_W{1'b0}};
            end else begin
               state_d = S_IDLE;
            end
         end
         S_BUSY: begin
            // Only completion or the watchdog ends the grant; the owner's op
            // is not looked at here.
            if (mem_tx_done || wd_expire_s) begin
               state_d = S_RELEASE;
               grant_d = {NUM_REQ{1'b0}};
               last_d  = gidx_q;
               wdog_d  = {WD_W{1'b0}};
            end else begin
               wdog_d  = wdog_q + {{(WD_W-1){1'b0}}, 1'b1};
            end
         end
         S_RELEASE: begin
            state_d = S_IDLE;
            grant_d = {NUM_REQ{1'b0}};
         end
         default: begin
            state_d = S_IDLE;
            grant_d = {NUM_REQ{1'b0}};
            wdog_d  = {WD_W{1'b0}};
         end
      endcase
   end

   // State registers; reset returns to IDLE with requester 0 next in line.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         grant_q <= {NUM_REQ{1'b0}};
         gidx_q  <= {IDX_W{1'b0}};
         last_q  <= LAST_RST;
         wdog_q  <= {WD_W{1'b0}};
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         gidx_q  <= gidx_d;
         last_q  <= last_d;
         wdog_q  <= wdog_d;
      end
   end

   // Port muxing: the owner's live request goes to mem_cntrl, and completion
   // signals go back to the owner only. Everything is quiet outside BUSY.
   always_comb begin
      mem_op       = 2'b00;
      mem_addr     = {ADDR_W{1'b0}};
      mem_wdata    = {DATA_W{1'b0}};
      req_rd_valid = {NUM_REQ{1'b0}};
      req_tx_done  = {NUM_REQ{1'b0}};
      if (state_q == S_BUSY) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (gidx_q == IDX_W'(i)) begin
               mem_op          = req_op[2*i +: 2];
               mem_addr        = req_addr[ADDR_W*i +: ADDR_W];
               mem_wdata       = req_wdata[DATA_W*i +: DATA_W];
               req_rd_valid[i] = mem_rd_valid;
               req_tx_done[i]  = mem_tx_done;
            end else begin
               req_rd_valid[i] = 1'b0;
               req_tx_done[i]  = 1'b0;
            end
         end
      end else begin
         mem_op = 2'b00;
      end
   end

   assign req_rdata   = mem_rdata;
   assign grant       = grant_q;
   assign busy        = (state_q == S_BUSY);
   assign timeout_err = wd_expire_s;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single mem_cntrl port (op / io_address / common data bus / tx_done / rd_valid) between NUM_REQ requesters; each requester uses the same port protocol as cpu.
- Round-robin grant, held for one full transaction (until mem_tx_done), followed by one dead cycle.
- A watchdog forces release if mem_cntrl never signals completion.
- Sits between the requester blocks (cpu, DMA engines) and mem_cntrl.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
ADDR_W, 64, address width
DATA_W, 32, data bus width
TIMEOUT, 1024, max cycles in BUSY before forced release (>=2)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
req_op  input  2*NUM_REQ  per-requester op, slice i = [2i+1:2i]; 00 NOP, 01 READ, 11 WRITE, 10 reserved (treated as NOP)
req_addr  input  ADDR_W*NUM_REQ  per-requester io_address
req_wdata  input  DATA_W*NUM_REQ  per-requester write data
req_rdata  output  DATA_W  read data, broadcast to all requesters
req_rd_valid  output  NUM_REQ  rd_valid, routed to the granted requester only
req_tx_done  output  NUM_REQ  tx_done, routed to the granted requester only
grant  output  NUM_REQ  one-hot current owner; all zero when not BUSY
mem_op  output  2  op to mem_cntrl
mem_addr  output  ADDR_W  io_address to mem_cntrl
mem_wdata  output  DATA_W  write data to mem_cntrl
mem_rdata  input  DATA_W  read data from mem_cntrl
mem_rd_valid  input  1  read beat valid
mem_tx_done  input  1  transaction complete
busy  output  1  high in BUSY
timeout_err  output  1  one-cycle pulse on forced release

Behaviour:
- Reset: state=IDLE; grant=0; last_grant=NUM_REQ-1, so requester 0 wins first; watchdog=0; timeout_err=0. Reset clears all of these immediately, including mid-transaction, and mem_op drops to 00 asynchronously.
- States: IDLE, BUSY, RELEASE.
- IDLE:
  - A requester is active when its op is 01 or 11.
  - If any requester is active, select the first active index searching last_grant+1, last_grant+2, … modulo NUM_REQ.
  - Register the selection into grant; go to BUSY next cycle. Grant latency is 1 cycle from op assertion.
  - If no requester is active, stay in IDLE.
- BUSY:
  - mem_op, mem_addr and mem_wdata are combinationally muxed from the granted slice.
  - req_rd_valid[g]=mem_rd_valid and req_tx_done[g]=mem_tx_done; all other bits are 0.
  - req_rdata=mem_rdata at all times, in every state.
  - The granted requester changing or dropping its op mid-transaction does not release the grant; only mem_tx_done or timeout releases it.
  - On mem_tx_done: last_grant<=g; go to RELEASE.
  - The watchdog increments each BUSY cycle and clears on entry to BUSY. On reaching TIMEOUT-1 without mem_tx_done:
    - pulse timeout_err for one cycle;
    - last_grant<=g; go to RELEASE;
    - do not drive req_tx_done.
  - If mem_tx_done and the timeout coincide, mem_tx_done wins and there is no timeout_err.
- RELEASE: lasts 1 cycle; grant=0; go to IDLE. This gives the finished requester a cycle to drop its op before re-arbitration.
- Outside BUSY: mem_op=00, mem_addr=0, mem_wdata=0; all req_rd_valid and req_tx_done bits are 0. mem_rd_valid and mem_tx_done are ignored.
- Fairness: a requester holding its op continuously is re-granted only after every other active requester has been served once.
- Single requester: back-to-back transactions have 2 idle cycles between mem_tx_done and the next mem_op (RELEASE + IDLE).
- Reserved op 10 is never granted.

Test Plan:
- Reset, then req0 op=01 addr=0x0 at cycle 0 -> grant=01 and mem_op=01 at cycle 1. Controller sends 16 mem_rd_valid beats then mem_tx_done -> req_rd_valid[0] pulses 16 times, req_rd_valid[1]=0, grant=00 the cycle after tx_done.
- req0 op=01 and req1 op=11 addr=0x400 asserted simultaneously from reset -> req0 granted first. After its tx_done, RELEASE, then req1 granted with mem_addr=0x400 and mem_wdata tracking req1 data.
- Both requesters hold op continuously over 4 transactions -> grant sequence is 0,1,0,1.
- Granted req1 drops op to 00 mid-transaction -> grant stays 10 until mem_tx_done, and mem_op follows req1's live op (00).
- TIMEOUT=8, no mem_tx_done -> timeout_err pulses once at the 8th BUSY cycle, req_tx_done stays 0, grant cleared, next requester granted. Also drive mem_tx_done in that same 8th cycle -> no timeout_err.
- rst_n low for 1 cycle mid-BUSY -> grant=0, mem_op=00 immediately, and the first grant after reset goes to req0.
- req0 op=10 alone -> state stays IDLE and mem_op stays 00.
